// File: rtl/ahb_matrix_pkg.sv
`default_nettype none
// ============================================================================
// ahb_matrix_pkg : shared AHB codes, port encodings and burst helper
// Revision 1.0
// ============================================================================
package ahb_matrix_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [1:0] {
        PORT_P0   = 2'b00,
        PORT_P1   = 2'b01,
        PORT_NONE = 2'b11
    } port_e;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_OWNED  = 2'b01,
        ARB_BURST  = 2'b10,
        ARB_LOCKED = 2'b11
    } arb_state_e;

    // Fixed-length bursts only; SINGLE and undefined INCR report 0.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                      return 5'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_output_arb_dma.sv
`default_nettype none
// ============================================================================
// ahb_output_arb_dma : two-port arbiter (state, beat counter, last grant)
// Revision 1.0
// ============================================================================
module ahb_output_arb_dma
    import ahb_matrix_pkg::*;
#(
    parameter int ARB_RR    = 1,
    parameter int PRIO_PORT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic       sel0,
    input  logic       sel1,
    input  logic [1:0] trans0,
    input  logic [1:0] trans1,
    input  logic [2:0] burst0,
    input  logic [2:0] burst1,
    input  logic       lock0,
    input  logic       lock1,
    output logic [1:0] addr_port
);

    localparam logic c_rr   = (ARB_RR != 0);
    localparam logic c_prio = (PRIO_PORT != 0);

    arb_state_e r_state, w_state_nxt;
    port_e      r_port, w_port_nxt;
    logic [4:0] r_count, w_count_nxt;
    logic       r_last, w_last_nxt;

    logic       w_own_sel, w_own_lock, w_win, w_any;
    logic [1:0] w_own_trans;
    logic [2:0] w_own_burst;
    logic [4:0] w_beats;
    logic       w_do_owned, w_do_rearb;

    always_comb begin
        w_own_sel   = 1'b0;
        w_own_trans = HTRANS_IDLE;
        w_own_burst = HBURST_SINGLE;
        w_own_lock  = 1'b0;
        case (r_port)
            PORT_P0: begin
                w_own_sel   = sel0;
                w_own_trans = trans0;
                w_own_burst = burst0;
                w_own_lock  = lock0;
            end
            PORT_P1: begin
                w_own_sel   = sel1;
                w_own_trans = trans1;
                w_own_burst = burst1;
                w_own_lock  = lock1;
            end
            default: ;
        endcase
    end

    assign w_beats = burst_beats(w_own_burst);
    assign w_any   = sel0 | sel1;
    // A sole requester (including the current owner) always wins.
    assign w_win   = (sel0 & sel1) ? (c_rr ? ~r_last : c_prio) : sel1;

    always_comb begin
        w_state_nxt = r_state;
        w_port_nxt  = r_port;
        w_count_nxt = r_count;
        w_last_nxt  = r_last;
        w_do_owned  = 1'b0;
        w_do_rearb  = 1'b0;

        case (r_state)
            ARB_IDLE:  w_do_rearb = 1'b1;
            ARB_OWNED: w_do_owned = 1'b1;
            ARB_BURST: begin
                if (!w_own_sel || w_own_trans == HTRANS_IDLE || w_own_trans == HTRANS_NONSEQ) begin
                    w_count_nxt = 5'd0;
                    w_do_owned  = 1'b1;
                end else if (w_own_trans == HTRANS_SEQ) begin
                    // The last beat hands over on its own ready edge, no bubble.
                    if (r_count <= 5'd1) begin
                        w_count_nxt = 5'd0;
                        if (w_own_lock)
                            w_state_nxt = ARB_LOCKED;
                        else
                            w_do_rearb = 1'b1;
                    end else begin
                        w_count_nxt = r_count - 5'd1;
                    end
                end
            end
            ARB_LOCKED: begin
                if (!(w_own_sel && w_own_lock))
                    w_do_rearb = 1'b1;
            end
            default: w_do_rearb = 1'b1;
        endcase

        if (w_do_owned) begin
            if (w_own_sel && w_own_trans == HTRANS_NONSEQ && w_beats != 5'd0) begin
                w_state_nxt = ARB_BURST;
                w_count_nxt = w_beats - 5'd1;
            end else if (w_own_sel && w_own_lock) begin
                w_state_nxt = ARB_LOCKED;
            end else if (w_own_sel && (w_own_trans == HTRANS_SEQ || w_own_trans == HTRANS_BUSY ||
                         (w_own_trans == HTRANS_NONSEQ && w_own_burst == HBURST_INCR))) begin
                w_state_nxt = ARB_OWNED;
            end else begin
                w_do_rearb = 1'b1;
            end
        end

        if (w_do_rearb) begin
            w_count_nxt = 5'd0;
            if (w_any) begin
                w_port_nxt  = port_e'({1'b0, w_win});
                w_last_nxt  = w_win;
                w_state_nxt = ARB_OWNED;
            end else begin
                w_port_nxt  = PORT_NONE;
                w_state_nxt = ARB_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
            r_port  <= PORT_NONE;
            r_count <= 5'd0;
            r_last  <= c_prio;
        end else if (ready) begin
            r_state <= w_state_nxt;
            r_port  <= w_port_nxt;
            r_count <= w_count_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign addr_port = r_port;

endmodule
`default_nettype wire

// File: rtl/ahb_output_stage_dma.sv
`default_nettype none
// ============================================================================
// ahb_output_stage_dma : slave-port output stage, address/data muxing
// Revision 1.0
// ============================================================================
module ahb_output_stage_dma
    import ahb_matrix_pkg::*;
#(
    parameter int ARB_RR    = 1,
    parameter int PRIO_PORT = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        sel_op0,
    input  logic [31:0] addr_op0,
    input  logic [1:0]  trans_op0,
    input  logic        write_op0,
    input  logic [2:0]  size_op0,
    input  logic [2:0]  burst_op0,
    input  logic [3:0]  prot_op0,
    input  logic        mastlock_op0,
    input  logic [31:0] wdata_op0,
    input  logic        sel_op1,
    input  logic [31:0] addr_op1,
    input  logic [1:0]  trans_op1,
    input  logic        write_op1,
    input  logic [2:0]  size_op1,
    input  logic [2:0]  burst_op1,
    input  logic [3:0]  prot_op1,
    input  logic        mastlock_op1,
    input  logic [31:0] wdata_op1,
    output logic        active_op0,
    output logic        active_op1,
    output logic        HSELM,
    output logic [31:0] HADDRM,
    output logic [1:0]  HTRANSM,
    output logic        HWRITEM,
    output logic [2:0]  HSIZEM,
    output logic [2:0]  HBURSTM,
    output logic [3:0]  HPROTM,
    output logic [3:0]  HMASTERM,
    output logic        HMASTLOCKM,
    output logic [31:0] HWDATAM,
    output logic        HREADYMUXM,
    input  logic        HREADYOUTM
);

    logic [1:0] w_addr_port;
    port_e      r_data_port;

    ahb_output_arb_dma #(
        .ARB_RR    (ARB_RR),
        .PRIO_PORT (PRIO_PORT)
    ) u_arb (
        .clk       (HCLK),
        .rst       (HRESET),
        .ready     (HREADYOUTM),
        .sel0      (sel_op0),
        .sel1      (sel_op1),
        .trans0    (trans_op0),
        .trans1    (trans_op1),
        .burst0    (burst_op0),
        .burst1    (burst_op1),
        .lock0     (mastlock_op0),
        .lock1     (mastlock_op1),
        .addr_port (w_addr_port)
    );

    always_comb begin
        HSELM      = 1'b0;
        HADDRM     = 32'd0;
        HTRANSM    = HTRANS_IDLE;
        HWRITEM    = 1'b0;
        HSIZEM     = 3'd0;
        HBURSTM    = 3'd0;
        HPROTM     = 4'd0;
        HMASTERM   = 4'd0;
        HMASTLOCKM = 1'b0;
        case (port_e'(w_addr_port))
            PORT_P0: begin
                HSELM      = sel_op0;
                HADDRM     = addr_op0;
                HTRANSM    = sel_op0 ? trans_op0 : HTRANS_IDLE;
                HWRITEM    = write_op0;
                HSIZEM     = size_op0;
                HBURSTM    = burst_op0;
                HPROTM     = prot_op0;
                HMASTERM   = 4'd0;
                HMASTLOCKM = mastlock_op0;
            end
            PORT_P1: begin
                HSELM      = sel_op1;
                HADDRM     = addr_op1;
                HTRANSM    = sel_op1 ? trans_op1 : HTRANS_IDLE;
                HWRITEM    = write_op1;
                HSIZEM     = size_op1;
                HBURSTM    = burst_op1;
                HPROTM     = prot_op1;
                HMASTERM   = 4'd1;
                HMASTLOCKM = mastlock_op1;
            end
            default: ;
        endcase
    end

    assign active_op0 = sel_op0 & (w_addr_port == PORT_P0);
    assign active_op1 = sel_op1 & (w_addr_port == PORT_P1);
    assign HREADYMUXM = HREADYOUTM;

    // Data-phase owner follows the address phase only for real transfers.
    always_ff @(posedge HCLK) begin
        if (HRESET)
            r_data_port <= PORT_NONE;
        else if (HREADYOUTM)
            r_data_port <= (HTRANSM == HTRANS_NONSEQ || HTRANSM == HTRANS_SEQ) ?
                           port_e'(w_addr_port) : PORT_NONE;
    end

    always_comb begin
        HWDATAM = 32'd0;
        case (r_data_port)
            PORT_P0: HWDATAM = wdata_op0;
            PORT_P1: HWDATAM = wdata_op1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_output_stage_dma.sv
`default_nettype none
// ============================================================================
// tb_ahb_output_stage_dma : directed bench for the slave-port output stage
// Revision 1.0
// ============================================================================
module tb_ahb_output_stage_dma;

    logic        HCLK, HRESET, HREADYOUTM;
    logic        sel_op0, write_op0, mastlock_op0;
    logic        sel_op1, write_op1, mastlock_op1;
    logic [31:0] addr_op0, wdata_op0, addr_op1, wdata_op1;
    logic [1:0]  trans_op0, trans_op1;
    logic [2:0]  size_op0, burst_op0, size_op1, burst_op1;
    logic [3:0]  prot_op0, prot_op1;

    logic        active_op0, active_op1, HSELM, HWRITEM, HMASTLOCKM, HREADYMUXM;
    logic [31:0] HADDRM, HWDATAM;
    logic [1:0]  HTRANSM;
    logic [2:0]  HSIZEM, HBURSTM;
    logic [3:0]  HPROTM, HMASTERM;

    logic        fp_active_op0, fp_active_op1, fp_HSELM, fp_HWRITEM, fp_HMASTLOCKM, fp_HREADYMUXM;
    logic [31:0] fp_HADDRM, fp_HWDATAM;
    logic [1:0]  fp_HTRANSM;
    logic [2:0]  fp_HSIZEM, fp_HBURSTM;
    logic [3:0]  fp_HPROTM, fp_HMASTERM;

    int n_cmp = 0;
    int n_err = 0;

    ahb_output_stage_dma #(.ARB_RR(1), .PRIO_PORT(0)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .sel_op0(sel_op0), .addr_op0(addr_op0), .trans_op0(trans_op0), .write_op0(write_op0),
        .size_op0(size_op0), .burst_op0(burst_op0), .prot_op0(prot_op0),
        .mastlock_op0(mastlock_op0), .wdata_op0(wdata_op0),
        .sel_op1(sel_op1), .addr_op1(addr_op1), .trans_op1(trans_op1), .write_op1(write_op1),
        .size_op1(size_op1), .burst_op1(burst_op1), .prot_op1(prot_op1),
        .mastlock_op1(mastlock_op1), .wdata_op1(wdata_op1),
        .active_op0(active_op0), .active_op1(active_op1),
        .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
        .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTERM(HMASTERM),
        .HMASTLOCKM(HMASTLOCKM), .HWDATAM(HWDATAM), .HREADYMUXM(HREADYMUXM),
        .HREADYOUTM(HREADYOUTM)
    );

    ahb_output_stage_dma #(.ARB_RR(0), .PRIO_PORT(1)) dut_fp (
        .HCLK(HCLK), .HRESET(HRESET),
        .sel_op0(sel_op0), .addr_op0(addr_op0), .trans_op0(trans_op0), .write_op0(write_op0),
        .size_op0(size_op0), .burst_op0(burst_op0), .prot_op0(prot_op0),
        .mastlock_op0(mastlock_op0), .wdata_op0(wdata_op0),
        .sel_op1(sel_op1), .addr_op1(addr_op1), .trans_op1(trans_op1), .write_op1(write_op1),
        .size_op1(size_op1), .burst_op1(burst_op1), .prot_op1(prot_op1),
        .mastlock_op1(mastlock_op1), .wdata_op1(wdata_op1),
        .active_op0(fp_active_op0), .active_op1(fp_active_op1),
        .HSELM(fp_HSELM), .HADDRM(fp_HADDRM), .HTRANSM(fp_HTRANSM), .HWRITEM(fp_HWRITEM),
        .HSIZEM(fp_HSIZEM), .HBURSTM(fp_HBURSTM), .HPROTM(fp_HPROTM), .HMASTERM(fp_HMASTERM),
        .HMASTLOCKM(fp_HMASTLOCKM), .HWDATAM(fp_HWDATAM), .HREADYMUXM(fp_HREADYMUXM),
        .HREADYOUTM(HREADYOUTM)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        sel_op0 = 1'b0; trans_op0 = 2'b00; burst_op0 = 3'b000; mastlock_op0 = 1'b0;
        sel_op1 = 1'b0; trans_op1 = 2'b00; burst_op1 = 3'b000; mastlock_op1 = 1'b0;
        HREADYOUTM = 1'b1;
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        idle_inputs();
        cyc();
        HRESET = 1'b0;
    endtask

    logic [31:0] exp_rr [4];

    initial begin
        HRESET = 1'b1;
        idle_inputs();
        addr_op0 = 32'd0; wdata_op0 = 32'd0; write_op0 = 1'b0; size_op0 = 3'd0; prot_op0 = 4'd0;
        addr_op1 = 32'd0; wdata_op1 = 32'd0; write_op1 = 1'b0; size_op1 = 3'd0; prot_op1 = 4'd0;

        // Reset held for two edges
        cyc(); cyc();
        @(negedge HCLK);
        chk("rst_hsel",    HSELM,      32'd0);
        chk("rst_htrans",  HTRANSM,    32'd0);
        chk("rst_active0", active_op0, 32'd0);
        chk("rst_active1", active_op1, 32'd0);
        chk("rst_hwdata",  HWDATAM,    32'd0);

        // Single write from P0
        cyc();
        HRESET = 1'b0;
        sel_op0 = 1'b1; trans_op0 = 2'b10; burst_op0 = 3'b000; write_op0 = 1'b1;
        addr_op0 = 32'h2000_0010; size_op0 = 3'd2; prot_op0 = 4'h3; wdata_op0 = 32'hA5A5_A5A5;
        @(negedge HCLK);
        chk("single_wait_active0", active_op0, 32'd0);
        chk("single_wait_htrans",  HTRANSM,    32'd0);
        cyc();
        @(negedge HCLK);
        chk("single_htrans",  HTRANSM,    32'd2);
        chk("single_haddr",   HADDRM,     32'h2000_0010);
        chk("single_active0", active_op0, 32'd1);
        chk("single_hwrite",  HWRITEM,    32'd1);
        chk("single_hsize",   HSIZEM,     32'd2);
        chk("single_hprot",   HPROTM,     32'h3);
        cyc();
        sel_op0 = 1'b0; trans_op0 = 2'b00;
        @(negedge HCLK);
        chk("single_hwdata", HWDATAM, 32'hA5A5_A5A5);
        chk("single_idle",   HTRANSM, 32'd0);
        cyc();
        @(negedge HCLK);
        chk("single_hwdata_done", HWDATAM, 32'd0);

        // P1 INCR4 holds the bus against a waiting P0
        do_reset();
        sel_op0 = 1'b1; trans_op0 = 2'b10; burst_op0 = 3'b000; addr_op0 = 32'h2000_0100; write_op0 = 1'b0;
        sel_op1 = 1'b1; trans_op1 = 2'b10; burst_op1 = 3'b011; addr_op1 = 32'h3000_0000; write_op1 = 1'b1;
        wdata_op1 = 32'h1111_0000;
        cyc();
        @(negedge HCLK);
        chk("burst_b0_master",  HMASTERM,   32'd1);
        chk("burst_b0_htrans",  HTRANSM,    32'd2);
        chk("burst_b0_active0", active_op0, 32'd0);
        chk("burst_b0_active1", active_op1, 32'd1);
        for (int b = 1; b < 4; b++) begin
            cyc();
            trans_op1 = 2'b11;
            addr_op1 = 32'h3000_0000 + 32'(4 * b);
            @(negedge HCLK);
            chk("burst_seq_haddr",   HADDRM,     32'h3000_0000 + 32'(4 * b));
            chk("burst_seq_htrans",  HTRANSM,    32'd3);
            chk("burst_seq_master",  HMASTERM,   32'd1);
            chk("burst_seq_active0", active_op0, 32'd0);
        end
        cyc();
        sel_op1 = 1'b0; trans_op1 = 2'b00;
        @(negedge HCLK);
        chk("handover_master",  HMASTERM,   32'd0);
        chk("handover_haddr",   HADDRM,     32'h2000_0100);
        chk("handover_htrans",  HTRANSM,    32'd2);
        chk("handover_active0", active_op0, 32'd1);
        chk("handover_hwdata",  HWDATAM,    32'h1111_0000);

        // Continuous SINGLE contention: RR alternates, fixed priority sticks to P1
        do_reset();
        sel_op0 = 1'b1; trans_op0 = 2'b10; burst_op0 = 3'b000; addr_op0 = 32'h2000_0200;
        cyc();
        sel_op1 = 1'b1; trans_op1 = 2'b10; burst_op1 = 3'b000; addr_op1 = 32'h3000_0200;
        @(negedge HCLK);
        chk("rr_first_master", HMASTERM,    32'd0);
        chk("fp_first_master", fp_HMASTERM, 32'd0);
        exp_rr[0] = 32'd1; exp_rr[1] = 32'd0; exp_rr[2] = 32'd1; exp_rr[3] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge HCLK);
            chk("rr_alt_master", HMASTERM,      exp_rr[i]);
            chk("rr_alt_htrans", HTRANSM,       32'd2);
            chk("fp_master",     fp_HMASTERM,   32'd1);
            chk("fp_active0",    fp_active_op0, 32'd0);
        end

        // Locked sequence from P0 with two wait states; P1 waits
        do_reset();
        sel_op0 = 1'b1; trans_op0 = 2'b10; burst_op0 = 3'b000; mastlock_op0 = 1'b1;
        addr_op0 = 32'h4000_0000;
        cyc();
        sel_op1 = 1'b1; trans_op1 = 2'b10; burst_op1 = 3'b000; addr_op1 = 32'h5000_0000;
        @(negedge HCLK);
        chk("lock_t1_haddr", HADDRM,     32'h4000_0000);
        chk("lock_t1_hlock", HMASTLOCKM, 32'd1);
        cyc();
        addr_op0 = 32'h4000_0004;
        HREADYOUTM = 1'b0;
        @(negedge HCLK);
        chk("lock_t2_haddr",   HADDRM,     32'h4000_0004);
        chk("lock_t2_hready",  HREADYMUXM, 32'd0);
        chk("lock_t2_active1", active_op1, 32'd0);
        cyc();
        @(negedge HCLK);
        chk("lock_wait1_haddr",   HADDRM,     32'h4000_0004);
        chk("lock_wait1_master",  HMASTERM,   32'd0);
        chk("lock_wait1_active0", active_op0, 32'd1);
        chk("lock_wait1_active1", active_op1, 32'd0);
        cyc();
        HREADYOUTM = 1'b1;
        @(negedge HCLK);
        chk("lock_wait2_haddr",   HADDRM,     32'h4000_0004);
        chk("lock_wait2_active1", active_op1, 32'd0);
        cyc();
        addr_op0 = 32'h4000_0008;
        @(negedge HCLK);
        chk("lock_t3_haddr",   HADDRM,     32'h4000_0008);
        chk("lock_t3_master",  HMASTERM,   32'd0);
        chk("lock_t3_active1", active_op1, 32'd0);
        cyc();
        sel_op0 = 1'b0; mastlock_op0 = 1'b0; trans_op0 = 2'b00;
        @(negedge HCLK);
        chk("unlock_htrans",  HTRANSM,    32'd0);
        chk("unlock_active1", active_op1, 32'd0);
        cyc();
        @(negedge HCLK);
        chk("p1_after_lock_master",  HMASTERM,   32'd1);
        chk("p1_after_lock_haddr",   HADDRM,     32'h5000_0000);
        chk("p1_after_lock_active1", active_op1, 32'd1);
        chk("p1_after_lock_hlock",   HMASTLOCKM, 32'd0);

        // Reset in the middle of an INCR8 from P1
        do_reset();
        sel_op1 = 1'b1; trans_op1 = 2'b10; burst_op1 = 3'b101; addr_op1 = 32'h6000_0000;
        cyc();
        @(negedge HCLK);
        chk("incr8_b1_htrans", HTRANSM, 32'd2);
        cyc();
        trans_op1 = 2'b11; addr_op1 = 32'h6000_0004;
        @(negedge HCLK);
        chk("incr8_b2_htrans", HTRANSM, 32'd3);
        chk("incr8_b2_haddr",  HADDRM,  32'h6000_0004);
        HRESET = 1'b1;
        cyc();
        HRESET = 1'b0;
        trans_op1 = 2'b10; burst_op1 = 3'b000; addr_op1 = 32'h6000_0100;
        @(negedge HCLK);
        chk("midrst_htrans",  HTRANSM,    32'd0);
        chk("midrst_hsel",    HSELM,      32'd0);
        chk("midrst_active1", active_op1, 32'd0);
        cyc();
        @(negedge HCLK);
        chk("postrst_htrans",  HTRANSM,    32'd2);
        chk("postrst_haddr",   HADDRM,     32'h6000_0100);
        chk("postrst_master",  HMASTERM,   32'd1);
        chk("postrst_active1", active_op1, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
